// File: rtl/param_processor.sv
// Multi-cycle register-file core: latch instruction, read operands, execute, store.
// Five-state FSM with a preload port and a combinational debug read port.
module param_processor #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_COUNT   = 1024,
    parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
    parameter int INSTR_WIDTH = 3 + 3 * ADDR_WIDTH
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_instr_valid,
    output logic                   o_instr_ready,
    input  logic [INSTR_WIDTH-1:0] i_instruction,
    input  logic                   i_load_valid,
    input  logic [ADDR_WIDTH-1:0]  i_load_addr,
    input  logic [DATA_WIDTH-1:0]  i_load_data,
    input  logic [ADDR_WIDTH-1:0]  i_dbg_addr,
    output logic [DATA_WIDTH-1:0]  o_dbg_data,
    output logic                   o_done,
    output logic [DATA_WIDTH-1:0]  o_result,
    output logic                   o_zero,
    output logic                   o_carry
);

    localparam int SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        EXECUTE,
        STORE
    } state_t;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0]  op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]  op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   carry_q, carry_d;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] rd;
    logic [ADDR_WIDTH-1:0] rs_1;
    logic [ADDR_WIDTH-1:0] rs_2;

    assign op   = instr_q[INSTR_WIDTH-1 -: 3];
    assign rd   = instr_q[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign rs_1 = instr_q[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign rs_2 = instr_q[ADDR_WIDTH-1:0];

    logic                  accept;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    // Preload owns the idle cycle, so it blocks acceptance.
    assign o_instr_ready = (state_q == IDLE) && !i_load_valid && !i_reset;
    assign accept        = o_instr_ready && i_instr_valid;

    // ALU: one extra bit on add/sub yields carry-out and borrow.
    logic [DATA_WIDTH:0]   add_full;
    logic [DATA_WIDTH:0]   sub_full;
    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_carry;

    assign add_full = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign sub_full = {1'b0, op_a_q} - {1'b0, op_b_q};
    assign shamt    = op_b_q[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = add_full[DATA_WIDTH-1:0];
                alu_carry = add_full[DATA_WIDTH];
            end
            OP_SUB: begin
                alu_res   = sub_full[DATA_WIDTH-1:0];
                alu_carry = sub_full[DATA_WIDTH];
            end
            OP_AND:  alu_res = op_a_q & op_b_q;
            OP_OR:   alu_res = op_a_q | op_b_q;
            OP_XOR:  alu_res = op_a_q ^ op_b_q;
            OP_SLL:  alu_res = op_a_q << shamt;
            OP_SRL:  alu_res = op_a_q >> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    instr_d = i_instruction;
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = (op == OP_NOP) ? IDLE : READ;
            READ: begin
                op_a_d  = regs[rs_1];
                op_b_d  = regs[rs_2];
                state_d = EXECUTE;
            end
            EXECUTE: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                carry_d  = alu_carry;
                state_d  = STORE;
            end
            STORE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A single write port shared by preload (idle only) and writeback.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = i_load_addr;
        rf_wdata = i_load_data;
        if (!i_reset) begin
            if (state_q == STORE) begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                rf_wdata = result_q;
            end else if (state_q == IDLE && i_load_valid) begin
                rf_we = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // Register file contents survive reset.
    always_ff @(posedge i_clock) begin
        if (rf_we) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign o_dbg_data = regs[i_dbg_addr];
    assign o_done     = (state_q == STORE) && !i_reset;
    assign o_result   = result_q;
    assign o_zero     = zero_q;
    assign o_carry    = carry_q;

endmodule

// File: tb/tb_param_processor.sv
// Self-checking bench for param_processor: directed scenarios plus random
// instructions checked against an arithmetic reference model of the register file.
module tb_param_processor;

    localparam int DW = 32;
    localparam int RC = 1024;
    localparam int AW = 10;
    localparam int IW = 3 + 3 * AW;

    logic          clk = 1'b0;
    logic          srst;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instruction;
    logic          load_valid;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          done;
    logic [DW-1:0] result;
    logic          zero;
    logic          carry;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model [RC];

    param_processor #(.DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
        .i_clock       (clk),
        .i_reset       (srst),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .i_instruction (instruction),
        .i_load_valid  (load_valid),
        .i_load_addr   (load_addr),
        .i_load_data   (load_data),
        .i_dbg_addr    (dbg_addr),
        .o_dbg_data    (dbg_data),
        .o_done        (done),
        .o_result      (result),
        .o_zero        (zero),
        .o_carry       (carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {carry, result} from the opcode's arithmetic definition.
    function automatic logic [DW:0] ref_op(input logic [2:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [DW:0] r;
        int          sh;
        sh = int'(b % DW);
        case (op)
            3'd1: r = {1'b0, a} + {1'b0, b};
            3'd2: r = {(a < b), a - b};
            3'd3: r = {1'b0, a & b};
            3'd4: r = {1'b0, a | b};
            3'd5: r = {1'b0, a ^ b};
            3'd6: r = {1'b0, a << sh};
            3'd7: r = {1'b0, a >> sh};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        model[a]   = d;
        $display("load r%0d = %h", a, d);
    endtask

    task automatic do_instr(input logic [2:0] op, input logic [AW-1:0] rd,
                            input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        logic [DW:0] e;
        int          n;
        e           = ref_op(op, model[rs1], model[rs2]);
        instruction = {op, rd, rs1, rs2};
        dbg_addr    = rd;
        instr_valid = 1'b1;
        #1;
        n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 64'(instr_ready), 64'd1);
            instr_valid = 1'b0;
            return;
        end
        tick();
        instr_valid = 1'b0;
        chk("busy_ready", 64'(instr_ready), 64'd0);
        chk("c1_done", 64'(done), 64'd0);
        if (op == 3'd0) begin
            tick();
            chk("nop_ready", 64'(instr_ready), 64'd1);
            chk("nop_done", 64'(done), 64'd0);
            chk("nop_reg", 64'(dbg_data), 64'(model[rd]));
            $display("instr NOP rd=%0d rs1=%0d rs2=%0d", rd, rs1, rs2);
            return;
        end
        tick();
        chk("c2_done", 64'(done), 64'd0);
        tick();
        chk("c3_done", 64'(done), 64'd0);
        tick();
        chk("c4_done", 64'(done), 64'd1);
        chk("c4_result", 64'(result), 64'(e[DW-1:0]));
        chk("c4_carry", 64'(carry), 64'(e[DW]));
        chk("c4_zero", 64'(zero), 64'(e[DW-1:0] == '0));
        chk("c4_old_reg", 64'(dbg_data), 64'(model[rd]));
        tick();
        model[rd] = e[DW-1:0];
        chk("c5_reg", 64'(dbg_data), 64'(model[rd]));
        chk("c5_ready", 64'(instr_ready), 64'd1);
        chk("c5_done", 64'(done), 64'd0);
        $display("instr op=%0d rd=%0d rs1=%0d rs2=%0d result=%h carry=%0d", op, rd, rs1, rs2,
                 result, carry);
    endtask

    initial begin
        int accepts;
        int dones;
        logic [DW-1:0] old20;
        logic [DW-1:0] old30;

        srst        = 1'b1;
        instr_valid = 1'b1;
        instruction = {3'd1, 10'd5, 10'd6, 10'd7};
        load_valid  = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        dbg_addr    = '0;

        // Reset held two cycles with an instruction offered.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ready", 64'(instr_ready), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_result", 64'(result), 64'd0);
        end
        srst        = 1'b0;
        instr_valid = 1'b0;
        tick();
        chk("post_rst_ready", 64'(instr_ready), 64'd1);
        chk("post_rst_flags", 64'({zero, carry}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_accept_in_rst", 64'(done), 64'd0);
        end
        $display("reset sequence complete");

        // ADD with carry-out.
        do_load(10'd995, 32'hFFFF_FFFF);
        do_load(10'd996, 32'h0000_0002);
        do_instr(3'd1, 10'd997, 10'd995, 10'd996);
        chk("add_const", 64'(dbg_data), 64'h0000_0001);

        // SUB fully aliased, then SUB with borrow.
        do_load(10'd998, 32'h1234_5678);
        do_instr(3'd2, 10'd998, 10'd998, 10'd998);
        chk("sub_alias_const", 64'(dbg_data), 64'h0);
        do_load(10'd2, 32'd5);
        do_load(10'd3, 32'd7);
        do_instr(3'd2, 10'd1, 10'd2, 10'd3);
        chk("sub_borrow_const", 64'(dbg_data), 64'hFFFF_FFFE);

        // Logic and shifts (shift amount uses only the low 5 bits of 0x24).
        do_load(10'd10, 32'hF0F0_F0F0);
        do_load(10'd11, 32'h0FF0_0FF0);
        do_load(10'd12, 32'h0000_0024);
        do_instr(3'd3, 10'd13, 10'd10, 10'd11);
        chk("and_const", 64'(dbg_data), 64'h00F0_00F0);
        do_instr(3'd4, 10'd14, 10'd10, 10'd11);
        chk("or_const", 64'(dbg_data), 64'hFFF0_FFF0);
        do_instr(3'd5, 10'd15, 10'd10, 10'd11);
        chk("xor_const", 64'(dbg_data), 64'hFF00_FF00);
        do_instr(3'd6, 10'd16, 10'd10, 10'd12);
        chk("sll_const", 64'(dbg_data), 64'h0F0F_0F00);
        do_instr(3'd7, 10'd17, 10'd10, 10'd12);
        chk("srl_const", 64'(dbg_data), 64'h0F0F_0F0F);

        // NOP: no write, ready after two cycles.
        do_load(10'd40, 32'hDEAD_BEEF);
        do_load(10'd41, 32'd1);
        do_load(10'd42, 32'd2);
        do_instr(3'd0, 10'd40, 10'd41, 10'd42);

        // Load and instruction offered together: load wins, instruction follows.
        instruction = {3'd1, 10'd43, 10'd44, 10'd41};
        instr_valid = 1'b1;
        load_valid  = 1'b1;
        load_addr   = 10'd44;
        load_data   = 32'h0000_0100;
        #1;
        chk("load_blocks_ready", 64'(instr_ready), 64'd0);
        tick();
        load_valid  = 1'b0;
        model[44]   = 32'h0000_0100;
        #1;
        chk("ready_after_load", 64'(instr_ready), 64'd1);
        do_instr(3'd1, 10'd43, 10'd44, 10'd41);
        chk("load_then_add", 64'(dbg_data), 64'h0000_0101);

        // Back-to-back valid: one accept per five cycles.
        accepts     = 0;
        dones       = 0;
        instruction = {3'd1, 10'd45, 10'd41, 10'd42};
        instr_valid = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) begin
            if (instr_ready) accepts++;
            if (done) dones++;
            tick();
        end
        instr_valid = 1'b0;
        model[45]   = 32'd3;
        chk("b2b_accepts", 64'(accepts), 64'd3);
        chk("b2b_dones", 64'(dones), 64'd3);
        dbg_addr = 10'd45;
        #1;
        chk("b2b_reg", 64'(dbg_data), 64'd3);
        $display("back-to-back accepts=%0d dones=%0d", accepts, dones);

        // Reset during EXECUTE; preload during DECODE is ignored.
        do_load(10'd20, 32'h0000_AAAA);
        do_load(10'd30, 32'h0000_5555);
        old20 = model[20];
        old30 = model[30];
        instruction = {3'd1, 10'd20, 10'd41, 10'd42};
        instr_valid = 1'b1;
        #1;
        chk("mid_ready", 64'(instr_ready), 64'd1);
        tick();
        instr_valid = 1'b0;
        load_valid  = 1'b1;
        load_addr   = 10'd30;
        load_data   = 32'h1111_1111;
        tick();
        load_valid  = 1'b0;
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        #1;
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ready", 64'(instr_ready), 64'd1);
        chk("abort_result", 64'(result), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'd0);
        end
        dbg_addr = 10'd20;
        #1;
        chk("abort_r20", 64'(dbg_data), 64'(old20));
        dbg_addr = 10'd30;
        #1;
        chk("decode_load_ignored", 64'(dbg_data), 64'(old30));
        $display("reset mid-op complete r20=%h r30=%h", old20, old30);

        // Random instructions over a preloaded register pool.
        for (int i = 0; i < 8; i++) begin
            do_load(10'(100 + i), $urandom);
        end
        do_load(10'd0, $urandom);
        for (int i = 0; i < 30; i++) begin
            logic [2:0]    op;
            logic [AW-1:0] rd;
            logic [AW-1:0] r1;
            logic [AW-1:0] r2;
            op = 3'($urandom_range(0, 7));
            rd = (i % 7 == 0) ? 10'd0 : 10'(100 + $urandom_range(0, 7));
            r1 = 10'(100 + $urandom_range(0, 7));
            r2 = (i % 5 == 0) ? 10'd0 : 10'(100 + $urandom_range(0, 7));
            do_instr(op, rd, r1, r2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
